tchk_stim_gen: RTL and testbench

- Synthesizable stimulus generator for the conditional setup/hold checks on clock-enable cells (CK, E, TE pins).
- Produces a programmable burst of CK rising edges. For each edge, one "victim" pin (E or TE) falls a set number of cycles before the CK rise and returns high a set number of cycles after it, while the other pin holds the check condition.
- Sits in the timing-check bench and drives the cell under check; the cell is the receiving end of these waveforms.

---
 rtl/tchk_pkg.sv | 18 +
 rtl/tchk_phase_cnt.sv | 40 ++++
 rtl/tchk_stim_gen.sv | 203 ++++++++++++++++++++
 tb/tb_tchk_stim_gen.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/tchk_pkg.sv
// Shared types and defaults for the clock-enable timing-check stimulus generator.
package tchk_pkg;

    localparam int CNT_W_DEF  = 8;
    localparam int EDGE_W_DEF = 8;

    // Victim pin select: MODE_E wiggles E with TE as condition, MODE_TE the reverse.
    localparam logic MODE_E  = 1'b0;
    localparam logic MODE_TE = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        RUN  = 2'd2,
        FIN  = 2'd3
    } state_e;

endpackage

// File: rtl/tchk_phase_cnt.sv
// Modulo counter 0..last that wraps to 0; clr forces the next value to 0.
// The next value is exported so the parent can register outputs that line up
// with the phase they belong to.
module tchk_phase_cnt #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic [W-1:0] last,
    output logic [W-1:0] cnt,
    output logic [W-1:0] cnt_nxt,
    output logic         wrap
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Next count: hold at 0 while cleared, otherwise count and wrap at last.
    always_comb begin
        wrap  = (cnt_q == last);
        cnt_d = cnt_q + 1'b1;
        if (clr || wrap) begin
            cnt_d = '0;
        end
    end

    // Phase register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt     = cnt_q;
    assign cnt_nxt = cnt_d;

endmodule

// File: rtl/tchk_stim_gen.sv
// Burst generator for CK/E/TE setup-hold checks on clock-enable cells.
// Every output is a flop whose next value is derived from the next FSM state
// and next phase, so pins change exactly in the cycle their phase is entered.
module tchk_stim_gen
    import tchk_pkg::*;
#(
    parameter int CNT_W  = CNT_W_DEF,
    parameter int EDGE_W = EDGE_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              mode,
    input  logic              cond_en,
    input  logic [CNT_W-1:0]  setup_cyc,
    input  logic [CNT_W-1:0]  hold_cyc,
    input  logic [CNT_W-1:0]  period_cyc,
    input  logic [EDGE_W-1:0] num_edges,
    output logic              ck_o,
    output logic              e_o,
    output logic              te_o,
    output logic              edge_stb,
    output logic [EDGE_W-1:0] edge_cnt,
    output logic              busy,
    output logic              done,
    output logic              err
);

    // Two guard bits so setup+hold+2 never wraps.
    localparam int SW = CNT_W + 2;

    state_e state_q, state_d;

    logic              mode_q, mode_d;
    logic              cond_q, cond_d;
    logic [CNT_W-1:0]  setup_q, setup_d;
    logic [CNT_W-1:0]  hold_q, hold_d;
    logic [CNT_W-1:0]  period_q, period_d;
    logic [EDGE_W-1:0] nedge_q, nedge_d;

    logic              ck_q, ck_d;
    logic              e_q, e_d;
    logic              te_q, te_d;
    logic              stb_q, stb_d;
    logic [EDGE_W-1:0] cnt_q, cnt_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    logic              accept;
    logic              cfg_ok;
    logic              ph_wrap;
    logic [CNT_W-1:0]  ph;
    logic [CNT_W-1:0]  ph_d;

    logic [SW-1:0]     ph_x, s_x, rise_ph, fall_raw, fall_ph, last_ph;
    logic              vic_low, ck_hi, stb_hit, vic, cpin;

    // Phase only advances while in RUN; entering RUN always starts at ph=0.
    tchk_phase_cnt #(.W(CNT_W)) u_ph (
        .clk     (clk),
        .rst     (rst),
        .clr     (state_q != RUN),
        .last    (period_q - 1'b1),
        .cnt     (ph),
        .cnt_nxt (ph_d),
        .wrap    (ph_wrap)
    );

    // Start acceptance, config latch and state transitions.
    always_comb begin
        state_d  = state_q;
        accept   = 1'b0;
        err_d    = 1'b0;
        mode_d   = mode_q;
        cond_d   = cond_q;
        setup_d  = setup_q;
        hold_d   = hold_q;
        period_d = period_q;
        nedge_d  = nedge_q;
        cfg_ok   = (SW'(period_cyc) >= SW'(setup_cyc) + SW'(hold_cyc) + SW'(2))
                   && (period_cyc >= CNT_W'(4));
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    if (cfg_ok) begin
                        accept  = 1'b1;
                        state_d = (num_edges == '0) ? FIN : ARM;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ARM:  state_d = RUN;
            RUN:  if (ph_wrap && (cnt_q == nedge_q)) state_d = FIN;
            FIN:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (accept) begin
            mode_d   = mode;
            cond_d   = cond_en;
            setup_d  = setup_cyc;
            hold_d   = hold_cyc;
            period_d = period_cyc;
            nedge_d  = num_edges;
        end
    end

    // Waveform decode for the next phase; CK fall is pushed to the last phase
    // when the half-period point would not come after the victim rise.
    always_comb begin
        ph_x     = SW'(ph_d);
        s_x      = SW'(setup_d);
        rise_ph  = s_x + SW'(hold_d) + SW'(1);
        fall_raw = s_x + SW'(period_d >> 1);
        last_ph  = SW'(period_d) - SW'(1);
        fall_ph  = fall_raw;
        if ((fall_raw <= rise_ph) || (fall_raw > last_ph)) begin
            fall_ph = last_ph;
        end
        vic_low = (ph_x < rise_ph);
        ck_hi   = (ph_x >= s_x) && (ph_x < fall_ph);
        stb_hit = (ph_x == s_x);
    end

    // Next values for the registered pins and status.
    always_comb begin
        vic    = 1'b1;
        cpin   = 1'b1;
        ck_d   = 1'b0;
        stb_d  = 1'b0;
        busy_d = 1'b0;
        done_d = 1'b0;
        cnt_d  = accept ? '0 : cnt_q;
        unique case (state_d)
            ARM: begin
                busy_d = 1'b1;
                cpin   = ~cond_d;
            end
            RUN: begin
                busy_d = 1'b1;
                cpin   = ~cond_d;
                vic    = ~vic_low;
                ck_d   = ck_hi;
                stb_d  = stb_hit;
                if (stb_hit && (cnt_q != nedge_d)) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            FIN:  done_d = 1'b1;
            default: ;
        endcase
        e_d  = (mode_d == MODE_E) ? vic : cpin;
        te_d = (mode_d == MODE_E) ? cpin : vic;
    end

    // State, config and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            mode_q   <= MODE_E;
            cond_q   <= 1'b0;
            setup_q  <= '0;
            hold_q   <= '0;
            period_q <= '0;
            nedge_q  <= '0;
            ck_q     <= 1'b0;
            e_q      <= 1'b1;
            te_q     <= 1'b1;
            stb_q    <= 1'b0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            mode_q   <= mode_d;
            cond_q   <= cond_d;
            setup_q  <= setup_d;
            hold_q   <= hold_d;
            period_q <= period_d;
            nedge_q  <= nedge_d;
            ck_q     <= ck_d;
            e_q      <= e_d;
            te_q     <= te_d;
            stb_q    <= stb_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    assign ck_o     = ck_q;
    assign e_o      = e_q;
    assign te_o     = te_q;
    assign edge_stb = stb_q;
    assign edge_cnt = cnt_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign err      = err_q;

endmodule

// File: tb/tb_tchk_stim_gen.sv
// Scoreboard bench: each burst pushes its expected per-cycle pin vectors,
// which are popped and compared at every falling clock edge.
module tb_tchk_stim_gen;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       mode = 1'b0;
    logic       cond_en = 1'b0;
    logic [7:0] setup_cyc = '0;
    logic [7:0] hold_cyc = '0;
    logic [7:0] period_cyc = '0;
    logic [7:0] num_edges = '0;
    logic       ck_o, e_o, te_o, edge_stb, busy, done, err;
    logic [7:0] edge_cnt;

    typedef struct packed {
        logic       ck;
        logic       e;
        logic       te;
        logic       stb;
        logic       busy;
        logic       done;
        logic       err;
        logic [7:0] cnt;
    } vec_t;

    vec_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   last_cnt = 0;

    always #5 clk = ~clk;

    tchk_stim_gen dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .cond_en(cond_en),
        .setup_cyc(setup_cyc), .hold_cyc(hold_cyc), .period_cyc(period_cyc),
        .num_edges(num_edges), .ck_o(ck_o), .e_o(e_o), .te_o(te_o),
        .edge_stb(edge_stb), .edge_cnt(edge_cnt), .busy(busy), .done(done), .err(err)
    );

    function automatic vec_t mk(input logic ck, e, te, stb, bsy, dn, er, input int cnt);
        vec_t v;
        v.ck = ck; v.e = e; v.te = te; v.stb = stb;
        v.busy = bsy; v.done = dn; v.err = er; v.cnt = 8'(cnt);
        return v;
    endfunction

    function automatic vec_t obs();
        return mk(ck_o, e_o, te_o, edge_stb, busy, done, err, int'(edge_cnt));
    endfunction

    // Expected waveform written from the pin-level description of a burst.
    task automatic push_burst(input logic md, input logic ce, input int s, h, p, n);
        int   f, cnt;
        logic v, c, ck;
        if (p < s + h + 2 || p < 4) begin
            q.push_back(mk(0, 1, 1, 0, 0, 0, 1, last_cnt));
            q.push_back(mk(0, 1, 1, 0, 0, 0, 0, last_cnt));
            return;
        end
        if (n == 0) begin
            q.push_back(mk(0, 1, 1, 0, 0, 1, 0, 0));
            q.push_back(mk(0, 1, 1, 0, 0, 0, 0, 0));
            last_cnt = 0;
            return;
        end
        c = ~ce;
        q.push_back(md ? mk(0, c, 1, 0, 1, 0, 0, 0) : mk(0, 1, c, 0, 1, 0, 0, 0));
        cnt = 0;
        for (int k = 0; k < n; k++) begin
            for (int ph = 0; ph < p; ph++) begin
                f = s + p / 2;
                if (f <= s + h + 1 || f > p - 1) f = p - 1;
                v  = !(ph <= s + h);
                ck = (ph >= s) && (ph < f);
                if (ph == s) cnt++;
                q.push_back(md ? mk(ck, c, v, ph == s, 1, 0, 0, cnt)
                               : mk(ck, v, c, ph == s, 1, 0, 0, cnt));
            end
        end
        q.push_back(mk(0, 1, 1, 0, 0, 1, 0, n));
        q.push_back(mk(0, 1, 1, 0, 0, 0, 0, n));
        last_cnt = n;
    endtask

    task automatic kick(input logic md, input logic ce, input int s, h, p, n);
        @(negedge clk);
        mode = md; cond_en = ce;
        setup_cyc = 8'(s); hold_cyc = 8'(h); period_cyc = 8'(p); num_edges = 8'(n);
        start = 1'b1;
        push_burst(md, ce, s, h, p, n);
    endtask

    // Pops and compares one vector per cycle; poke >= 0 re-pulses start
    // with a different config at that cycle index.
    task automatic run_expect(input string nm, input int poke, input int maxn,
                              output int stbs, output int done_at);
        vec_t e, o;
        int   i;
        i = 0; stbs = 0; done_at = -1;
        while (q.size() > 0 && i < maxn) begin
            @(negedge clk);
            e = q.pop_front();
            o = obs();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL %s cyc%0d got=%h exp=%h", nm, i, o, e);
            end
            if (o.stb) stbs++;
            if (o.done && done_at < 0) done_at = i;
            start = (i == poke);
            if (i == poke) begin
                num_edges = 8'd9; period_cyc = 8'd20; setup_cyc = 8'd0;
            end
            i++;
        end
        start = 1'b0;
    endtask

    task automatic test_reset;
        @(negedge clk);
        checks++;
        if (obs() !== mk(0, 1, 1, 0, 0, 0, 0, 0)) begin
            errors++;
            $display("FAIL reset_state got=%h", obs());
        end
        rst = 1'b0;
    endtask

    task automatic test_basic;
        int stbs, dat;
        kick(0, 1, 2, 1, 8, 3);
        run_expect("basic", -1, 1000, stbs, dat);
        checks++;
        if (dat !== 25) begin
            errors++;
            $display("FAIL basic_done_cycle got=%0d exp=25", dat);
        end
        checks++;
        if (edge_cnt !== 8'd3) begin
            errors++;
            $display("FAIL basic_edge_cnt got=%0d exp=3", edge_cnt);
        end
    endtask

    task automatic test_mode_te;
        int stbs, dat;
        kick(1, 0, 0, 0, 4, 2);
        run_expect("mode_te", -1, 1000, stbs, dat);
        checks++;
        if (stbs !== 2) begin
            errors++;
            $display("FAIL mode_te_stb_count got=%0d exp=2", stbs);
        end
    endtask

    task automatic test_boundary;
        int stbs, dat;
        kick(0, 1, 3, 3, 8, 1);
        run_expect("p_min_ok", -1, 1000, stbs, dat);
        kick(0, 1, 3, 3, 7, 1);
        run_expect("p_reject", -1, 1000, stbs, dat);
        kick(1, 1, 0, 0, 3, 1);
        run_expect("p_lt4", -1, 1000, stbs, dat);
    endtask

    task automatic test_zero_edges;
        int stbs, dat;
        kick(0, 1, 1, 1, 6, 0);
        run_expect("zero_edges", -1, 1000, stbs, dat);
        checks++;
        if (dat !== 0) begin
            errors++;
            $display("FAIL zero_edges_done got=%0d exp=0", dat);
        end
    endtask

    task automatic test_busy_start;
        int stbs, dat;
        kick(1, 1, 1, 0, 4, 2);
        run_expect("busy_start", 3, 1000, stbs, dat);
        checks++;
        if (stbs !== 2) begin
            errors++;
            $display("FAIL busy_start_edges got=%0d exp=2", stbs);
        end
    endtask

    task automatic test_reset_mid;
        int stbs, dat, seen;
        kick(0, 1, 2, 1, 8, 3);
        run_expect("pre_reset", -1, 5, stbs, dat);
        q.delete();
        rst = 1'b1;
        #1;
        checks++;
        if ({ck_o, e_o, te_o, busy} !== 4'b0110) begin
            errors++;
            $display("FAIL reset_mid got=%b exp=0110", {ck_o, e_o, te_o, busy});
        end
        @(negedge clk);
        rst = 1'b0;
        last_cnt = 0;
        seen = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (done) seen++;
        end
        checks++;
        if (seen !== 0) begin
            errors++;
            $display("FAIL reset_no_done got=%0d exp=0", seen);
        end
        kick(0, 0, 1, 2, 6, 2);
        run_expect("post_reset", -1, 1000, stbs, dat);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        test_reset();
        test_basic();
        test_mode_te();
        test_boundary();
        test_zero_edges();
        test_busy_start();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
